core_haz_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order core pipeline; successor to the fixed 4-stage hazard_ctrl.

---
 rtl/core_haz_if.sv | 48 ++++
 rtl/core_haz_unit.sv | 125 ++++++++++++
 tb/tb_core_haz_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_haz_if.sv
// Decode-side hazard bus: DEC operand info and stall sources in,
// pipeline register controls, bypass selects and perf counters out.
interface core_haz_if #(
    parameter int STAGES = 3,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = $clog2(STAGES + 1)
);
    logic              dec_val_in;
    logic [RA_W-1:0]   dec_rs1_in;
    logic              dec_rs1_use_in;
    logic [RA_W-1:0]   dec_rs2_in;
    logic              dec_rs2_use_in;
    logic [RA_W-1:0]   dec_rd_in;
    logic              dec_we_in;
    logic              dec_load_in;
    logic              brnch_tknn_in;
    logic              stall_l1i_in;
    logic              stall_l1d_in;
    logic [STAGES:0]   enb_bus_out;
    logic [STAGES:0]   kill_bus_out;
    logic              pc_stop_out;
    logic              nop_gen_out;
    logic [SEL_W-1:0]  bp_rs1_out;
    logic [SEL_W-1:0]  bp_rs2_out;
    logic [CNT_W-1:0]  stall_cnt_out;
    logic [CNT_W-1:0]  flush_cnt_out;

    modport master (
        output dec_val_in, dec_rs1_in, dec_rs1_use_in,
        output dec_rs2_in, dec_rs2_use_in, dec_rd_in,
        output dec_we_in, dec_load_in, brnch_tknn_in,
        output stall_l1i_in, stall_l1d_in,
        input  enb_bus_out, kill_bus_out, pc_stop_out,
        input  nop_gen_out, bp_rs1_out, bp_rs2_out,
        input  stall_cnt_out, flush_cnt_out
    );

    modport slave (
        input  dec_val_in, dec_rs1_in, dec_rs1_use_in,
        input  dec_rs2_in, dec_rs2_use_in, dec_rd_in,
        input  dec_we_in, dec_load_in, brnch_tknn_in,
        input  stall_l1i_in, stall_l1d_in,
        output enb_bus_out, kill_bus_out, pc_stop_out,
        output nop_gen_out, bp_rs1_out, bp_rs2_out,
        output stall_cnt_out, flush_cnt_out
    );
endinterface

// File: rtl/core_haz_unit.sv
// Hazard/forwarding controller: registered scoreboard of the stages after
// decode, pipeline enables/kills, bypass selects, saturating perf counters.
module core_haz_unit #(
    parameter int STAGES   = 3,
    parameter int RA_W     = 5,
    parameter int LOAD_FWD = 3,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input logic       clk,
    input logic       rst,
    core_haz_if.slave bus
);
    typedef struct packed {
        logic            val;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } sb_t;

    localparam sb_t BUBBLE = '0;

    sb_t              sb_q [1:STAGES];
    sb_t              sb1_d;
    logic             adv;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [SEL_W-1:0] sel1, sel2;
    logic             lu1, lu2, lu;
    logic             c_l1d, c_br, c_lu, c_l1i, c_nrm;
    logic [STAGES:0]  enb, kill;
    logic             pc_stop, nop;

    function automatic logic hit(sb_t e, logic [RA_W-1:0] rs, logic en);
        return e.val && e.we && (e.rd != '0) && (e.rd == rs) && en;
    endfunction

    // Walk from the oldest stage so the youngest (nearest) match wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        lu1  = 1'b0;
        lu2  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit(sb_q[k], bus.dec_rs1_in, bus.dec_rs1_use_in)) begin
                sel1 = SEL_W'(k);
                lu1  = sb_q[k].ld && (k < LOAD_FWD);
            end
            if (hit(sb_q[k], bus.dec_rs2_in, bus.dec_rs2_use_in)) begin
                sel2 = SEL_W'(k);
                lu2  = sb_q[k].ld && (k < LOAD_FWD);
            end
        end
    end

    assign lu    = bus.dec_val_in && (lu1 || lu2);
    assign c_l1d = bus.stall_l1d_in;
    assign c_br  = !c_l1d && bus.brnch_tknn_in;
    assign c_lu  = !c_l1d && !bus.brnch_tknn_in && lu;
    assign c_l1i = !c_l1d && !bus.brnch_tknn_in && !lu
                   && bus.stall_l1i_in;
    assign c_nrm = !(c_l1d || c_br || c_lu || c_l1i);

    always_comb begin
        enb     = '1;
        kill    = '0;
        pc_stop = 1'b0;
        nop     = 1'b0;
        adv     = 1'b1;
        sb1_d   = BUBBLE;
        stall_d = stall_q;
        flush_d = flush_q;
        unique case (1'b1)
            c_l1d: begin
                enb     = '0;
                pc_stop = 1'b1;
                adv     = 1'b0;
            end
            c_br: begin
                kill[1:0] = 2'b11;
                nop       = 1'b1;
                if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
            end
            c_lu, c_l1i: begin
                enb[0]  = 1'b0;
                kill[1] = 1'b1;
                pc_stop = 1'b1;
                nop     = 1'b1;
                if (c_lu && stall_q != '1) stall_d = stall_q + CNT_W'(1);
            end
            c_nrm: begin
                if (bus.dec_val_in) begin
                    sb1_d = '{val: 1'b1, rd: bus.dec_rd_in,
                              we: bus.dec_we_in, ld: bus.dec_load_in};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) sb_q[k] <= BUBBLE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (adv) begin
                sb_q[1] <= sb1_d;
                for (int k = 2; k <= STAGES; k++) sb_q[k] <= sb_q[k-1];
            end
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // While reset is held the pipeline is parked: nothing loads, all clears.
    assign bus.enb_bus_out   = rst ? '0 : enb;
    assign bus.kill_bus_out  = rst ? '1 : kill;
    assign bus.pc_stop_out   = rst | pc_stop;
    assign bus.nop_gen_out   = rst | nop;
    assign bus.bp_rs1_out    = rst ? '0 : sel1;
    assign bus.bp_rs2_out    = rst ? '0 : sel2;
    assign bus.stall_cnt_out = stall_q;
    assign bus.flush_cnt_out = flush_q;
endmodule

// File: tb/tb_core_haz_unit.sv
// Bench for core_haz_unit: directed scenarios plus randomized traffic
// checked against a stage-array model of the hazard rules.
module tb_core_haz_unit;
  localparam int ST = 3;
  localparam int RW = 5;
  localparam int LF = 3;
  localparam int CW = 2;
  localparam int SW = $clog2(ST + 1);
  localparam int OW = 2 * (ST + 1) + 2 + 2 * SW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_haz_if #(.STAGES(ST), .RA_W(RW), .CNT_W(CW), .SEL_W(SW)) bus ();

  core_haz_unit #(
    .STAGES(ST), .RA_W(RW), .LOAD_FWD(LF), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tot = 0;
  int n_pass = 0;

  bit m_v[0:ST];
  int m_rd[0:ST];
  bit m_we[0:ST];
  bit m_ld[0:ST];
  int m_sc, m_fc;

  logic [ST:0] e_enb, e_kill;
  logic e_pc, e_nop;
  logic [SW-1:0] e_bp1, e_bp2;
  int e_case;

  function automatic logic [OW-1:0] obs();
    return {bus.enb_bus_out, bus.kill_bus_out, bus.pc_stop_out,
            bus.nop_gen_out, bus.bp_rs1_out, bus.bp_rs2_out};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {e_enb, e_kill, e_pc, e_nop, e_bp1, e_bp2};
  endfunction

  function automatic int nearest(int rs, bit en);
    if (!en || rs == 0) return 0;
    for (int k = 1; k <= ST; k++)
      if (m_v[k] && m_we[k] && m_rd[k] == rs) return k;
    return 0;
  endfunction

  task automatic m_clear();
    for (int k = 0; k <= ST; k++) m_v[k] = 0;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_eval();
    int n1, n2;
    bit lu;
    n1 = nearest(int'(bus.dec_rs1_in), bus.dec_rs1_use_in);
    n2 = nearest(int'(bus.dec_rs2_in), bus.dec_rs2_use_in);
    lu = bus.dec_val_in && ((n1 != 0 && m_ld[n1] && n1 < LF) ||
                            (n2 != 0 && m_ld[n2] && n2 < LF));
    e_bp1 = SW'(n1);
    e_bp2 = SW'(n2);
    e_enb = '1;
    e_kill = '0;
    e_pc = 0;
    e_nop = 0;
    if (rst) begin
      e_case = 0; e_enb = '0; e_kill = '1; e_pc = 1; e_nop = 1;
      e_bp1 = '0; e_bp2 = '0;
    end else if (bus.stall_l1d_in) begin
      e_case = 1; e_enb = '0; e_pc = 1;
    end else if (bus.brnch_tknn_in) begin
      e_case = 2; e_kill[1:0] = 2'b11; e_nop = 1;
    end else if (lu || bus.stall_l1i_in) begin
      e_case = lu ? 3 : 4;
      e_enb[0] = 0; e_kill[1] = 1; e_pc = 1; e_nop = 1;
    end else begin
      e_case = 5;
    end
  endtask

  task automatic tick();
    bit nv, nwe, nld;
    int nrd;
    model_eval();
    nv = bus.dec_val_in;
    nrd = int'(bus.dec_rd_in);
    nwe = bus.dec_we_in;
    nld = bus.dec_load_in;
    @(posedge clk);
    if (rst) m_clear();
    else if (e_case != 1) begin
      for (int k = ST; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1];
        m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[1] = (e_case == 5) && nv;
      m_rd[1] = nrd; m_we[1] = nwe; m_ld[1] = nld;
      if (e_case == 2 && m_fc < CMAX) m_fc++;
      if (e_case == 3 && m_sc < CMAX) m_sc++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int r1, input bit u1,
                       input int r2, input bit u2, input int rd,
                       input bit we, input bit ld);
    bus.dec_val_in = v;
    bus.dec_rs1_in = RW'(r1);
    bus.dec_rs1_use_in = u1;
    bus.dec_rs2_in = RW'(r2);
    bus.dec_rs2_use_in = u2;
    bus.dec_rd_in = RW'(rd);
    bus.dec_we_in = we;
    bus.dec_load_in = ld;
  endtask

  task automatic ctl(input bit br, input bit i, input bit d);
    bus.brnch_tknn_in = br;
    bus.stall_l1i_in = i;
    bus.stall_l1d_in = d;
  endtask

  task automatic test_reset();
    logic [OW-1:0] rexp;
    rexp = {{(ST+1){1'b0}}, {(ST+1){1'b1}}, 2'b11, {(2*SW){1'b0}}};
    rst = 1; m_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0); ctl(0, 0, 0);
    #1;
    n_tot++;
    if (obs() !== rexp)
      $display("FAIL reset_out got %h exp %h", obs(), rexp);
    else n_pass++;
    n_tot++;
    if ({bus.stall_cnt_out, bus.flush_cnt_out} !== '0)
      $display("FAIL reset_cnt got %h exp 0",
               {bus.stall_cnt_out, bus.flush_cnt_out});
    else n_pass++;
    @(posedge clk); #1;
    rst = 0;
    #1; model_eval();
    n_tot++;
    if (bus.enb_bus_out !== {(ST+1){1'b1}} || obs() !== expv())
      $display("FAIL reset_release got %h exp %h", obs(), expv());
    else n_pass++;
  endtask

  task automatic test_fwd_chain();
    int want[4] = '{1, 2, 3, 0};
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    drive(0, 5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1; model_eval();
      n_tot++;
      if (bus.bp_rs1_out !== SW'(want[i]) || obs() !== expv())
        $display("FAIL fwd_chain[%0d] got bp %0d/%h exp bp %0d/%h",
                 i, bus.bp_rs1_out, obs(), want[i], expv());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 0, 0, 7, 1, 8, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1; model_eval();
      n_tot++;
      if ({bus.enb_bus_out, bus.kill_bus_out, bus.pc_stop_out,
           bus.nop_gen_out} !== {4'b1110, 4'b0010, 2'b11}
          || obs() !== expv())
        $display("FAIL load_use_stall[%0d] got %h exp %h",
                 i, obs(), expv());
      else n_pass++;
      tick();
    end
    #1;
    n_tot++;
    if (bus.bp_rs2_out !== SW'(3) || bus.pc_stop_out !== 1'b0)
      $display("FAIL load_use_fwd got bp %0d pc %b exp bp 3 pc 0",
               bus.bp_rs2_out, bus.pc_stop_out);
    else n_pass++;
    n_tot++;
    if (bus.stall_cnt_out !== CW'(2) || m_sc != 2)
      $display("FAIL load_use_cnt got %0d exp 2", bus.stall_cnt_out);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch_l1d();
    ctl(1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1; model_eval();
      n_tot++;
      if (bus.enb_bus_out !== '0 || bus.kill_bus_out !== '0
          || obs() !== expv())
        $display("FAIL br_l1d_hold[%0d] got %h exp %h", i, obs(), expv());
      else n_pass++;
      tick();
    end
    ctl(1, 0, 0);
    #1; model_eval();
    n_tot++;
    if (bus.kill_bus_out[1:0] !== 2'b11 || obs() !== expv())
      $display("FAIL br_flush got %h exp %h", obs(), expv());
    else n_pass++;
    tick();
    ctl(0, 0, 0);
    #1;
    n_tot++;
    if (bus.flush_cnt_out !== CW'(1) || m_fc != 1)
      $display("FAIL br_cnt got %0d exp 1", bus.flush_cnt_out);
    else n_pass++;
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 0, 1, 0, 1, 1, 1, 0);
    #1; model_eval();
    n_tot++;
    if (bus.bp_rs1_out !== '0 || bus.pc_stop_out !== 1'b0
        || obs() !== expv())
      $display("FAIL x0_nohaz got %h exp %h", obs(), expv());
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 4, 1, 0); tick();
    drive(0, 3, 1, 4, 1, 0, 0, 0);
    #1;
    n_tot++;
    if (bus.bp_rs1_out !== SW'(2) || bus.bp_rs2_out !== SW'(1))
      $display("FAIL pre_reset_bp got %0d/%0d exp 2/1",
               bus.bp_rs1_out, bus.bp_rs2_out);
    else n_pass++;
    rst = 1; m_clear();
    #1;
    n_tot++;
    if ({bus.stall_cnt_out, bus.flush_cnt_out, bus.bp_rs1_out,
         bus.bp_rs2_out, bus.enb_bus_out} !== '0)
      $display("FAIL mid_reset got cnt %0d/%0d bp %0d/%0d enb %b exp 0",
               bus.stall_cnt_out, bus.flush_cnt_out, bus.bp_rs1_out,
               bus.bp_rs2_out, bus.enb_bus_out);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0;
    #1; model_eval();
    n_tot++;
    if (bus.bp_rs1_out !== '0 || bus.bp_rs2_out !== '0
        || bus.enb_bus_out !== {(ST+1){1'b1}} || obs() !== expv())
      $display("FAIL post_reset got %h exp %h", obs(), expv());
    else n_pass++;
  endtask

  task automatic test_sat();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 9, 1, 1); tick();
      drive(1, 9, 1, 0, 0, 0, 0, 0); tick(); tick(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tot++;
    if (bus.stall_cnt_out !== CW'(CMAX) || m_sc != CMAX)
      $display("FAIL stall_sat got %0d exp %0d", bus.stall_cnt_out, CMAX);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      ctl($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0);
      #1; model_eval();
      n_tot++;
      if (obs() !== expv() || bus.stall_cnt_out !== CW'(m_sc)
          || bus.flush_cnt_out !== CW'(m_fc)) begin
        if (bad < 10)
          $display("FAIL rand[%0d] got %h cnt %0d/%0d exp %h cnt %0d/%0d",
                   i, obs(), bus.stall_cnt_out, bus.flush_cnt_out,
                   expv(), m_sc, m_fc);
        bad++;
      end else n_pass++;
      tick();
    end
    ctl(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fwd_chain();
    test_load_use();
    test_branch_l1d();
    test_x0();
    test_mid_reset();
    test_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
